risc_controller: RTL and testbench
==================================

# risc_controller

Multi-cycle Moore control FSM for the Simple RISC Machine. It fetches, decodes and sequences each 16-bit instruction through the register-file/ALU/shifter datapath and memory interface, including conditional branches evaluated from the registered Z/N/V status flags. It sits beside the datapath and drives every load-enable, mux-select, ALU opcode and memory command; it holds no datapath state itself.

## Interface
- DATA_WIDTH, 16, instruction width; the decode fields below assume 16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction register contents; decoded only after IR loads.
- Z, N, V  in  1 each  status-register outputs (registered ALU flags).
- nsel  out  2  register-file index select: 0 Rn, 1 Rd, 2 Rm.
- vsel  out  2  write-back source: 0 C, 1 PC, 2 sximm8, 3 mdata.
- write, loada, loadb, loadc, loads  out  1 each  register enables.
- asel  out  1  1 forces A operand to 0.
- bsel  out  1  1 selects sximm5 as B operand.
- alu_op  out  2  ALU operation (00 add, 01 sub, 10 and, 11 not-B).
- load_ir, load_pc, reset_pc, load_addr  out  1 each.
- pc_sel  out  1  0 PC+1, 1 PC+sx(imm8).
- addr_sel  out  1  1 memory address = PC, 0 = data address register.
- mem_cmd  out  2  00 none, 01 read, 10 write.
- halted  out  1  high in HALT.

## Operation
- Decode fields: opcode = instr[15:13], op = instr[12:11], cond = instr[10:8]. Rn, Rd and Rm indexing is done by the datapath from nsel.
- All outputs are 0 unless listed for a state. Outputs are a pure function of state, except DECODE's branch outputs.
- RESET: reset_pc=1, load_pc=1. Next state is IF1.
- IF1: addr_sel=1, mem_cmd=01.
- IF2: addr_sel=1, mem_cmd=01, load_ir=1.
- UPDATE_PC: load_pc=1, pc_sel=0. Next state is DECODE.
- DECODE: dispatches on {opcode, op}:
  - 110_10 (MOV imm) goes to WR_IMM.
  - 110_00 (MOV reg) and 101_11 (MVN) go to GET_B.
  - 101_00, 101_01, 101_10 (ADD/CMP/AND) go to GET_A.
  - 011_00 (LDR) and 100_00 (STR) go to GET_A.
  - 111 goes to HALT.
  - 001 (branch): evaluate taken. B(000)=1; BEQ(001)=Z; BNE(010)=~Z; BLT(011)=N^V; BLE(100)=Z|(N^V); other conds = 0.
  - Taken: load_pc=1, pc_sel=1 in DECODE. Next state is IF1 in either case.
  - Any other encoding is a NOP and goes to IF1.
- WR_IMM: nsel=0, vsel=2, write=1. Next state is IF1.
- GET_A: nsel=0, loada=1. Next state is GET_B for ALU ops, or MEM_ADDR for LDR/STR.
- GET_B: nsel=2, loadb=1. Next state is EXEC.
- EXEC: alu_op=op, loadc=1.
  - MOV reg: asel=1, alu_op=00.
  - CMP: loads=1, loadc=0, alu_op=01, next state IF1.
  - All others: next state WR_REG.
- WR_REG: nsel=1, vsel=0, write=1. Next state is IF1.
- MEM_ADDR: bsel=1, alu_op=00, loadc=1. Next state is LD_ADDR.
- LD_ADDR: load_addr=1. Next state is MEM_RD (LDR) or GET_D (STR).
- MEM_RD: addr_sel=0, mem_cmd=01. Next state is WR_MEM.
- WR_MEM: mem_cmd=01, nsel=1, vsel=3, write=1. Next state is IF1.
- GET_D: nsel=1, loadb=1. Next state is PASS_D.
- PASS_D: asel=1, alu_op=00, loadc=1. Next state is MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=10. Next state is IF1.
- HALT: halted=1. Absorbing; only rst_n leaves it.

## Timing
- rst_n low forces RESET immediately, from any state mid-instruction; no partial write completes after the reset edge.
- First IF1 is on the first clk edge after rst_n rises.
- Every instruction spends 4 cycles in IF1, IF2, UPDATE_PC and DECODE, then:
  - MOV imm: +1 cycle, 5 total.
  - MOV reg and MVN: +3, 7 total.
  - CMP: +3, 7 total.
  - ADD and AND: +4, 8 total.
  - LDR: +5, 9 total.
  - STR: +6, 10 total.
  - Branch (taken or not): 4 total.
- Memory is synchronous read: data appears the cycle after mem_cmd=01 with a valid address, hence the two-cycle fetch and read.
- PC increments in UPDATE_PC, so a branch target is (address of branch + 1 + sx(imm8)).
- Flags used in DECODE are those loaded by the most recent CMP. Back-to-back CMP followed by a branch is legal: loads takes effect at the end of CMP's EXEC, before the next DECODE.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> state RESET, reset_pc=load_pc=1, all other outputs 0. Release -> IF1 next cycle.
- MOV R0,#5 (16'hD005) -> in the WR_IMM cycle: vsel=2, nsel=0, write=1. IF1 follows; 5 cycles total per instruction.
- ADD R2,R1,R0 (16'hA140) -> state sequence GET_A, GET_B, EXEC (alu_op=00, loadc=1), WR_REG (nsel=1, write=1).
- CMP with flags driven Z=0, N=1, V=0, then BLT (16'h2305) -> in DECODE: load_pc=1, pc_sel=1. With V=1 instead -> no load_pc.
- LDR (16'h6000) -> 9-cycle instruction with mem_cmd=01 in MEM_RD and WR_MEM, vsel=3 at write. STR (16'h8000) -> 10 cycles, mem_cmd=10 exactly once.
- HALT (16'hE000) -> halted=1 and stays in HALT for 20 cycles. Pulse rst_n low mid-LDR -> RESET asynchronously, write never asserted.

Source files
------------

// File: rtl/risc_controller.sv
// risc_controller: multi-cycle Moore control FSM for the Simple RISC Machine.
// Sequences fetch, PC update, decode and the per-instruction micro-steps,
// driving every datapath enable, mux select, ALU opcode and memory command.
module risc_controller #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  Z,
  input  logic                  N,
  input  logic                  V,
  output logic [1:0]            nsel,
  output logic [1:0]            vsel,
  output logic                  write,
  output logic                  loada,
  output logic                  loadb,
  output logic                  loadc,
  output logic                  loads,
  output logic                  asel,
  output logic                  bsel,
  output logic [1:0]            alu_op,
  output logic                  load_ir,
  output logic                  load_pc,
  output logic                  reset_pc,
  output logic                  load_addr,
  output logic                  pc_sel,
  output logic                  addr_sel,
  output logic [1:0]            mem_cmd,
  output logic                  halted
);

  localparam logic [4:0] S_RESET     = 5'd0;
  localparam logic [4:0] S_IF1       = 5'd1;
  localparam logic [4:0] S_IF2       = 5'd2;
  localparam logic [4:0] S_UPDATE_PC = 5'd3;
  localparam logic [4:0] S_DECODE    = 5'd4;
  localparam logic [4:0] S_WR_IMM    = 5'd5;
  localparam logic [4:0] S_GET_A     = 5'd6;
  localparam logic [4:0] S_GET_B     = 5'd7;
  localparam logic [4:0] S_EXEC      = 5'd8;
  localparam logic [4:0] S_WR_REG    = 5'd9;
  localparam logic [4:0] S_MEM_ADDR  = 5'd10;
  localparam logic [4:0] S_LD_ADDR   = 5'd11;
  localparam logic [4:0] S_MEM_RD    = 5'd12;
  localparam logic [4:0] S_WR_MEM    = 5'd13;
  localparam logic [4:0] S_GET_D     = 5'd14;
  localparam logic [4:0] S_PASS_D    = 5'd15;
  localparam logic [4:0] S_MEM_WR    = 5'd16;
  localparam logic [4:0] S_HALT      = 5'd17;

  logic [4:0] r_state;
  logic [4:0] w_next;
  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_cond;
  logic [4:0] w_opc_op;
  logic       w_taken;
  logic       w_unused_bits;

  assign w_opcode      = instr[15:13];
  assign w_op          = instr[12:11];
  assign w_cond        = instr[10:8];
  assign w_opc_op      = {w_opcode, w_op};
  // Register indices and immediates are consumed by the datapath, not here.
  assign w_unused_bits = ^instr[7:0];

  // Branch condition from the registered status flags.
  always_comb begin
    w_taken = 1'b0;
    case (w_cond)
      3'b000:  w_taken = 1'b1;
      3'b001:  w_taken = Z;
      3'b010:  w_taken = ~Z;
      3'b011:  w_taken = N ^ V;
      3'b100:  w_taken = Z | (N ^ V);
      default: w_taken = 1'b0;
    endcase
  end

  // State register; reset is asynchronous so a pending write is abandoned at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  // Next-state sequencing through fetch, decode and per-instruction steps.
  always_comb begin
    w_next = S_RESET;
    case (r_state)
      S_RESET:     w_next = S_IF1;
      S_IF1:       w_next = S_IF2;
      S_IF2:       w_next = S_UPDATE_PC;
      S_UPDATE_PC: w_next = S_DECODE;
      S_DECODE: begin
        case (w_opc_op)
          5'b110_10:                     w_next = S_WR_IMM;
          5'b110_00, 5'b101_11:          w_next = S_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10,
          5'b011_00, 5'b100_00:          w_next = S_GET_A;
          default: w_next = (w_opcode == 3'b111) ? S_HALT : S_IF1;
        endcase
      end
      S_WR_IMM:    w_next = S_IF1;
      S_GET_A:     w_next = (w_opcode == 3'b011 || w_opcode == 3'b100) ? S_MEM_ADDR : S_GET_B;
      S_GET_B:     w_next = S_EXEC;
      S_EXEC:      w_next = (w_opc_op == 5'b101_01) ? S_IF1 : S_WR_REG;
      S_WR_REG:    w_next = S_IF1;
      S_MEM_ADDR:  w_next = S_LD_ADDR;
      S_LD_ADDR:   w_next = (w_opcode == 3'b011) ? S_MEM_RD : S_GET_D;
      S_MEM_RD:    w_next = S_WR_MEM;
      S_WR_MEM:    w_next = S_IF1;
      S_GET_D:     w_next = S_PASS_D;
      S_PASS_D:    w_next = S_MEM_WR;
      S_MEM_WR:    w_next = S_IF1;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_RESET;
    endcase
  end

  // Moore outputs per state; only DECODE's PC load looks at instr and flags.
  always_comb begin
    nsel      = 2'd0;
    vsel      = 2'd0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    alu_op    = 2'b00;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    pc_sel    = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = 2'b00;
    halted    = 1'b0;
    case (r_state)
      S_RESET: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = 2'b01;
        load_ir  = 1'b1;
      end
      S_UPDATE_PC: load_pc = 1'b1;
      S_DECODE: begin
        if (w_opcode == 3'b001 && w_taken) begin
          load_pc = 1'b1;
          pc_sel  = 1'b1;
        end
      end
      S_WR_IMM: begin
        vsel  = 2'd2;
        write = 1'b1;
      end
      S_GET_A: loada = 1'b1;
      S_GET_B: begin
        nsel  = 2'd2;
        loadb = 1'b1;
      end
      S_EXEC: begin
        if (w_opcode == 3'b110) begin
          // MOV reg passes B through an adder with A forced to zero.
          asel  = 1'b1;
          loadc = 1'b1;
        end else if (w_opc_op == 5'b101_01) begin
          // CMP only updates the status register.
          loads  = 1'b1;
          alu_op = 2'b01;
        end else begin
          alu_op = w_op;
          loadc  = 1'b1;
        end
      end
      S_WR_REG: begin
        nsel  = 2'd1;
        write = 1'b1;
      end
      S_MEM_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd = 2'b01;
      S_WR_MEM: begin
        mem_cmd = 2'b01;
        nsel    = 2'd1;
        vsel    = 2'd3;
        write   = 1'b1;
      end
      S_GET_D: begin
        nsel  = 2'd1;
        loadb = 1'b1;
      end
      S_PASS_D: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MEM_WR: mem_cmd = 2'b10;
      S_HALT:   halted  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_controller.sv
// Testbench for risc_controller: instruction-level reference model producing the
// expected per-cycle control word, compared against the DUT on every falling edge.
module tb_risc_controller;

  typedef struct packed {
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] alu_op;
    logic       load_ir, load_pc, reset_pc, load_addr, pc_sel, addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        Z, N, V;
  logic [1:0]  nsel, vsel, alu_op, mem_cmd;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic        load_ir, load_pc, reset_pc, load_addr, pc_sel, addr_sel, halted;

  ctl_t w_dut;
  ctl_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  risc_controller #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .Z(Z), .N(N), .V(V),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .alu_op(alu_op),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .load_addr(load_addr), .pc_sel(pc_sel), .addr_sel(addr_sel),
    .mem_cmd(mem_cmd), .halted(halted)
  );

  assign w_dut = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, alu_op,
                  load_ir, load_pc, reset_pc, load_addr, pc_sel, addr_sel, mem_cmd, halted};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic ctl_t v_reset();
    ctl_t c = '0;
    c.reset_pc = 1'b1;
    c.load_pc  = 1'b1;
    return c;
  endfunction

  // Reference model: appends the control word of every cycle the instruction
  // takes (fetch through final step) and returns the cycle count.
  function automatic int push_instr(input logic [15:0] ins, input logic z, input logic n, input logic v);
    ctl_t c;
    logic [2:0] opc;
    logic [1:0] op;
    logic [2:0] cnd;
    logic       tk;
    int         len;
    opc = ins[15:13];
    op  = ins[12:11];
    cnd = ins[10:8];
    len = 4;
    c = '0; c.addr_sel = 1; c.mem_cmd = 2'b01; exp_q.push_back(c);
    c.load_ir = 1; exp_q.push_back(c);
    c = '0; c.load_pc = 1; exp_q.push_back(c);
    c = '0;
    if (opc == 3'b001) begin
      case (cnd)
        3'd0: tk = 1'b1;
        3'd1: tk = z;
        3'd2: tk = !z;
        3'd3: tk = (n != v);
        3'd4: tk = z || (n != v);
        default: tk = 1'b0;
      endcase
      if (tk) begin c.load_pc = 1; c.pc_sel = 1; end
    end
    exp_q.push_back(c);
    if (opc == 3'b110 && op == 2'b10) begin
      c = '0; c.vsel = 2; c.write = 1; exp_q.push_back(c);
      len = 5;
    end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101)) begin
      if (opc == 3'b101 && op != 2'b11) begin
        c = '0; c.loada = 1; exp_q.push_back(c); len++;
      end
      c = '0; c.nsel = 2; c.loadb = 1; exp_q.push_back(c);
      c = '0;
      if (opc == 3'b110) begin c.asel = 1; c.loadc = 1; end
      else if (op == 2'b01) begin c.loads = 1; c.alu_op = 2'b01; end
      else begin c.alu_op = op; c.loadc = 1; end
      exp_q.push_back(c);
      len += 2;
      if (!(opc == 3'b101 && op == 2'b01)) begin
        c = '0; c.nsel = 1; c.write = 1; exp_q.push_back(c); len++;
      end
    end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
      c = '0; c.loada = 1; exp_q.push_back(c);
      c = '0; c.bsel = 1; c.loadc = 1; exp_q.push_back(c);
      c = '0; c.load_addr = 1; exp_q.push_back(c);
      if (opc == 3'b011) begin
        c = '0; c.mem_cmd = 2'b01; exp_q.push_back(c);
        c.nsel = 1; c.vsel = 3; c.write = 1; exp_q.push_back(c);
        len = 9;
      end else begin
        c = '0; c.nsel = 1; c.loadb = 1; exp_q.push_back(c);
        c = '0; c.asel = 1; c.loadc = 1; exp_q.push_back(c);
        c = '0; c.mem_cmd = 2'b10; exp_q.push_back(c);
        len = 10;
      end
    end
    return len;
  endfunction

  task automatic run(input logic [15:0] ins, input logic z, input logic n, input logic v);
    int cyc;
    instr = ins; Z = z; N = n; V = v;
    cyc = push_instr(ins, z, n, v);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of the DUT control word against the model.
  always @(negedge clk) begin
    if (chk_en && exp_q.size() > 0) begin
      ctl_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (w_dut !== e) begin
        n_fail++;
        $display("FAIL ctl_word t=%0t instr=%h got=%h want=%h", $time, instr, w_dut, e);
      end
    end
  end

  initial begin
    int   len;
    int   wr_cnt;
    logic [15:0] ins;
    logic [4:0]  top;
    rst_n = 1'b0; instr = '0; Z = 0; N = 0; V = 0;

    // Hand-computed pins on the model itself.
    len = push_instr(16'hD005, 0, 0, 0);
    check("mov_imm_len", len, 5);
    check("mov_imm_wr", {exp_q[4].nsel, exp_q[4].vsel, exp_q[4].write}, 5'b00_10_1);
    exp_q.delete();
    len = push_instr(16'hA140, 0, 0, 0);
    check("add_len", len, 8);
    check("add_exec", {exp_q[6].alu_op, exp_q[6].loadc, exp_q[7].nsel, exp_q[7].write}, 6'b00_1_01_1);
    exp_q.delete();
    len = push_instr(16'hA900, 0, 0, 0);
    check("cmp_len", len, 7);
    exp_q.delete();
    len = push_instr(16'h2305, 0, 1, 0);
    check("blt_taken", {len[3:0], exp_q[3].load_pc, exp_q[3].pc_sel}, {4'd4, 2'b11});
    exp_q.delete();
    len = push_instr(16'h2305, 0, 1, 1);
    check("blt_not_taken", exp_q[3].load_pc, 1'b0);
    exp_q.delete();
    len = push_instr(16'h6000, 0, 0, 0);
    check("ldr_len", len, 9);
    check("ldr_rd", {exp_q[7].mem_cmd, exp_q[8].mem_cmd, exp_q[8].vsel}, 6'b01_01_11);
    exp_q.delete();
    len = push_instr(16'h8000, 0, 0, 0);
    wr_cnt = 0;
    foreach (exp_q[i]) if (exp_q[i].mem_cmd == 2'b10) wr_cnt++;
    check("str_len", len, 10);
    check("str_one_write", wr_cnt, 1);
    exp_q.delete();

    // Reset held three cycles, then release.
    chk_en = 1'b1;
    repeat (3) exp_q.push_back(v_reset());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence.
    run(16'hD005, 0, 0, 0);
    run(16'hA140, 0, 0, 0);
    run(16'hA900, 0, 1, 0);
    run(16'h2305, 0, 1, 0);
    run(16'hA900, 0, 1, 1);
    run(16'h2305, 0, 1, 1);
    run(16'h6000, 0, 0, 0);
    run(16'h8000, 0, 0, 0);

    // Reset pulse while LDR is about to write back.
    instr = 16'h6000;
    len = push_instr(16'h6000, 0, 0, 0);
    void'(exp_q.pop_back());
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.push_back(v_reset());
    exp_q.push_back(v_reset());
    @(negedge clk);
    check("async_reset_no_write", {write, reset_pc, load_pc}, 3'b011);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized instruction mix with random flags.
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0: top = 5'b110_10;
        1: top = 5'b110_00;
        2: top = 5'b101_11;
        3: top = 5'b101_00;
        4: top = 5'b101_01;
        5: top = 5'b101_10;
        6: top = 5'b011_00;
        7: top = 5'b100_00;
        8: top = {3'b001, 2'($urandom_range(0, 3))};
        default: top = {3'b000, 2'($urandom_range(0, 3))};
      endcase
      ins = {top, 11'($urandom)};
      run(ins, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // HALT is absorbing.
    instr = 16'hE000;
    len = push_instr(16'hE000, 0, 0, 0);
    repeat (20) begin
      ctl_t h;
      h = '0; h.halted = 1'b1;
      exp_q.push_back(h);
    end
    repeat (len + 20) @(posedge clk);
    #1;
    check("halt_still", halted, 1'b1);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
